// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: two-master round-robin arbiter and transaction sequencer
// for the GPIO peripheral register bus. One transaction at a time:
// grant -> single-cycle select -> bounded wait for p_ready -> response pulse.
module gpio_bus_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_valid,
    input  logic [3:0]        m0_wstrb,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_valid,
    input  logic [3:0]        m1_wstrb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic              p_select,
    output logic [3:0]        p_wstrb,
    output logic [ADDR_W-1:0] p_addr,
    output logic [31:0]       p_data_i,
    input  logic              p_ready,
    input  logic [31:0]       p_data_o,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Last counter value before a timeout completion is forced.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                p_select_q, p_select_d;
    logic [3:0]          p_wstrb_q, p_wstrb_d;
    logic [ADDR_W-1:0]   p_addr_q, p_addr_d;
    logic [31:0]         p_data_i_q, p_data_i_d;
    logic                m0_ready_q, m0_ready_d;
    logic [31:0]         m0_rdata_q, m0_rdata_d;
    logic                m0_err_q, m0_err_d;
    logic                m1_ready_q, m1_ready_d;
    logic [31:0]         m1_rdata_q, m1_rdata_d;
    logic                m1_err_q, m1_err_d;
    logic                busy_q, busy_d;
    logic                pick_s;
    logic                resp_go_s;
    logic [31:0]         resp_rdata_s;
    logic                resp_err_s;

    // Next-state, arbitration and response computation for all flops.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        p_select_d   = 1'b0;
        p_wstrb_d    = p_wstrb_q;
        p_addr_d     = p_addr_q;
        p_data_i_d   = p_data_i_q;
        m0_ready_d   = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m0_err_d     = m0_err_q;
        m1_ready_d   = 1'b0;
        m1_rdata_d   = m1_rdata_q;
        m1_err_d     = m1_err_q;
        pick_s       = 1'b0;
        resp_go_s    = 1'b0;
        resp_rdata_s = 32'h0000_0000;
        resp_err_s   = 1'b0;

        // Round-robin: on contention the master that did not win last time goes.
        if (m0_valid && m1_valid) begin
            pick_s = ~last_grant_q;
        end else if (m1_valid) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    grant_d      = pick_s;
                    last_grant_d = pick_s;
                    p_select_d   = 1'b1;
                    state_d      = SEL;
                    if (pick_s) begin
                        p_wstrb_d  = m1_wstrb;
                        p_addr_d   = m1_addr;
                        p_data_i_d = m1_wdata;
                    end else begin
                        p_wstrb_d  = m0_wstrb;
                        p_addr_d   = m0_addr;
                        p_data_i_d = m0_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SEL: begin
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (p_ready) begin
                    resp_go_s    = 1'b1;
                    // Writes return zero regardless of what the peripheral drives.
                    resp_rdata_s = (p_wstrb_q != 4'h0) ? 32'h0000_0000 : p_data_o;
                    resp_err_s   = 1'b0;
                    state_d      = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    resp_go_s    = 1'b1;
                    resp_rdata_s = TMO_DATA;
                    resp_err_s   = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Route the completion to the granted master only.
        if (resp_go_s && grant_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = resp_rdata_s;
            m1_err_d   = resp_err_s;
        end else if (resp_go_s) begin
            m0_ready_d = 1'b1;
            m0_rdata_d = resp_rdata_s;
            m0_err_d   = resp_err_s;
        end else begin
            m0_ready_d = 1'b0;
            m1_ready_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; asynchronous reset drops any transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= 8'd0;
            p_select_q   <= 1'b0;
            p_wstrb_q    <= 4'h0;
            p_addr_q     <= '0;
            p_data_i_q   <= 32'h0000_0000;
            m0_ready_q   <= 1'b0;
            m0_rdata_q   <= 32'h0000_0000;
            m0_err_q     <= 1'b0;
            m1_ready_q   <= 1'b0;
            m1_rdata_q   <= 32'h0000_0000;
            m1_err_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            p_select_q   <= p_select_d;
            p_wstrb_q    <= p_wstrb_d;
            p_addr_q     <= p_addr_d;
            p_data_i_q   <= p_data_i_d;
            m0_ready_q   <= m0_ready_d;
            m0_rdata_q   <= m0_rdata_d;
            m0_err_q     <= m0_err_d;
            m1_ready_q   <= m1_ready_d;
            m1_rdata_q   <= m1_rdata_d;
            m1_err_q     <= m1_err_d;
            busy_q       <= busy_d;
        end
    end

    assign m0_ready = m0_ready_q;
    assign m0_rdata = m0_rdata_q;
    assign m0_err   = m0_err_q;
    assign m1_ready = m1_ready_q;
    assign m1_rdata = m1_rdata_q;
    assign m1_err   = m1_err_q;
    assign p_select = p_select_q;
    assign p_wstrb  = p_wstrb_q;
    assign p_addr   = p_addr_q;
    assign p_data_i = p_data_i_q;
    assign busy     = busy_q;

endmodule
